// File: rtl/mux_arb_pkg.sv
// Shared constants, state encoding and helpers for the 4-way round-robin mux arbiter.
package mux_arb_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic {IDLE, GRANT} state_e;

  function automatic logic [NUM_REQ-1:0] onehot2(input logic [SEL_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set request searching from ptr upward, mod 4.
module rr_pick4
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [SEL_W-1:0]   idx,
  output logic               found
);

  logic [SEL_W-1:0] cand;

  // Walk the search order backwards so the earliest hit is the one left standing.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = ptr + SEL_W'(i);
      if (req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning the mux4 select lines, with registered data and a tenure cap.
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned DATA_W   = 1,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   in_data,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [SEL_W-1:0]            sel,
  output logic                        busy,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_valid
);

  localparam int unsigned CNT_W = $clog2(MAX_HOLD) + 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_e              state_q;
  logic [SEL_W-1:0]    ptr_q;
  logic [SEL_W-1:0]    sel_q;
  logic [NUM_REQ-1:0]  gnt_q;
  logic                busy_q;
  logic [DATA_W-1:0]   out_data_q;
  logic                out_valid_q;
  logic [CNT_W-1:0]    hold_cnt_q;

  logic [SEL_W-1:0]    pick_idx;
  logic                pick_found;
  logic                owner_req;
  logic                rel_now;
  logic [DATA_W-1:0]   owner_data;

  rr_pick4 u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Timeout and request drop collapse into a single release.
  always_comb begin
    owner_req  = req[sel_q];
    owner_data = in_data[int'(sel_q)*DATA_W +: DATA_W];
    rel_now    = !owner_req || (hold_cnt_q == HOLD_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      sel_q       <= '0;
      gnt_q       <= '0;
      busy_q      <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      hold_cnt_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          out_valid_q <= 1'b0;
          if (pick_found) begin
            gnt_q      <= onehot2(pick_idx);
            sel_q      <= pick_idx;
            busy_q     <= 1'b1;
            hold_cnt_q <= '0;
            state_q    <= GRANT;
          end
        end
        GRANT: begin
          if (owner_req) begin
            out_data_q  <= owner_data;
            out_valid_q <= 1'b1;
            hold_cnt_q  <= hold_cnt_q + CNT_W'(1);
          end else begin
            out_valid_q <= 1'b0;
          end
          if (rel_now) begin
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= sel_q + SEL_W'(1);
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign busy      = busy_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
Round-robin arbiter and sequencer for the shared 4-to-1 multiplexer datapath. Four requesters each present a data word and a request line. The block grants the mux to one requester at a time, drives the mux select lines, registers the selected data, and caps tenure with a hold timer so no requester starves the others. It sits directly in front of the mux4 datapath and owns its select inputs.

Parameters:
DATA_W, 1, width of each requester data word and of out_data
MAX_HOLD, 8, maximum consecutive GRANT cycles per tenure (legal range 1..255)

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst_n  input  1  asynchronous, active-low reset
req  input  4  per-requester request; req[i] high means requester i wants the mux
in_data  input  4*DATA_W  requester data; slice i is in_data[i*DATA_W +: DATA_W]
gnt  output  4  one-hot grant, registered
sel  output  2  mux select {s1,s0}, registered; binary index of the granted requester
busy  output  1  high while in GRANT
out_data  output  DATA_W  registered mux output
out_valid  output  1  out_data holds a word transferred for the current owner

Behaviour:
- Reset (async, rst_n=0): state=IDLE, gnt=0, sel=0, busy=0, out_data=0, out_valid=0, ptr=0, hold_cnt=0. Asserting reset mid-tenure clears everything immediately. No transfer completes.
- ptr is the highest-priority index. Search order is ptr, ptr+1, ... mod 4.
- IDLE:
  - If req != 0, pick the first set bit in search order.
  - Next edge: gnt=onehot(idx), sel=idx, busy=1, hold_cnt=0, state=GRANT.
  - If req == 0, stay in IDLE; outputs hold.
- GRANT, owner o = sel:
  - Each cycle with req[o]=1: out_data <= in_data slice o, out_valid <= 1, hold_cnt++.
  - Release occurs when req[o]=0, or when hold_cnt == MAX_HOLD-1 with req[o]=1. If both happen in the same cycle, release once.
  - On the release edge: gnt=0, busy=0, ptr=(o+1) mod 4 (3 wraps to 0), state=IDLE. sel keeps its last value.
  - out_valid on the release edge is 1 only if req[o] was 1 in that cycle; otherwise 0. out_valid is 0 in every IDLE cycle after that.
- Requests from non-owners during GRANT are ignored until IDLE. Each tenure therefore has one dead IDLE cycle before the next grant.
- Latency: req rises in cycle N while IDLE → gnt/sel valid after edge N+1 → first out_valid after edge N+2.
- A timed-out owner that keeps req high may win again only when no other req is set, because ptr moved past it.
- out_data is not cleared when out_valid falls; it holds its last value.
- hold_cnt width is clog2(MAX_HOLD)+1 and it must not overflow.

Decomposition:
- Package mux_arb_pkg holds:
  - NUM_REQ=4 and SEL_W=2
  - state enum {IDLE, GRANT}
  - function onehot2 (2-bit index → 4-bit one-hot)
- One combinational sub-module, rr_pick4:
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: idx[1:0], found.
  - The top level holds the FSM, ptr, hold_cnt and the output registers.

Test Plan:
1. Reset behaviour: pulse rst_n low between clock edges with req=4'b1111 → all outputs 0 asynchronously. After release, the first grant is gnt=0001, sel=0.
2. Single requester, latency and data: req=0100, slice 2 = 1, others 0, for 3 cycles, then drop. Required: gnt=0100 and sel=2 one edge after req; out_valid=1, out_data=1 for 3 consecutive cycles starting the next edge; then gnt=0, busy=0, ptr=3.
3. Rotation fairness: hold req=1111, each owner dropping req after 1 cycle and re-raising it. Grants must cycle 0001→0010→0100→1000→0001, with the 1000→0001 step exercising the ptr wrap.
4. Timeout: MAX_HOLD=8, req=0011 held constantly. Owner 0 gets exactly 8 out_valid cycles, then one IDLE cycle, then gnt=0010. Requester 0 must not regain the mux before requester 1 is served.
5. Simultaneous drop and timeout: owner drops req on the cycle hold_cnt=7. Exactly one release occurs, out_valid=0 on that edge, and no double ptr advance (ptr=o+1).
6. Reset mid-tenure: assert rst_n=0 during the 4th GRANT cycle of owner 3. Outputs clear immediately, ptr=0, and after reset with req=1001 the grant goes to requester 0.
